// File: rtl/counter_pkg.sv
// counter_pkg: shared types and constants for the counter decode path
package counter_pkg;
   typedef enum logic [1:0] {IDLE, TRACK, FAULT} dec_state_t;
   typedef enum logic [2:0] {HOLD, UP, DOWN, RESTART, ILLEGAL} step_t;
   localparam int DEF_WIDTH = 8;
   localparam logic [7:0] ERR_MAX = 8'd255;
endpackage

// File: rtl/counter_step_classify.sv
// counter_step_classify: combinational step classifier between two counter samples
// Ports: prev (last sample), cnt_in (new sample) -> step class, wrap_up, wrap_down
module counter_step_classify
   import counter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] prev,
   input  logic [WIDTH-1:0] cnt_in,
   output step_t            step,
   output logic             wrap_up,
   output logic             wrap_down
);
   logic [WIDTH-1:0] delta;
   // Priority order matters: 255->0 must read as UP and 0->0 as HOLD, never RESTART
   always_comb begin
      delta     = cnt_in - prev;
      step      = delta == '0 ? HOLD :
                  delta == WIDTH'(1) ? UP :
                  &delta ? DOWN :
                  cnt_in == '0 ? RESTART : ILLEGAL;
      wrap_up   = step == UP && &prev;
      wrap_down = step == DOWN && prev == '0;
   end
endmodule

// File: rtl/counter_decoder.sv
// counter_decoder: recovers enable/direction from sampled counter values, flags wraps, restarts and illegal steps
// Ports: clk, rst (async active-low), cnt_in/cnt_valid in; step_valid, enable_out, direction_out,
//        wrap_up, wrap_down, restart, err pulses, locked level, err_count (saturating) out
module counter_decoder
   import counter_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int LOCK_LEN = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             cnt_valid,
   output logic             step_valid,
   output logic             enable_out,
   output logic             direction_out,
   output logic             wrap_up,
   output logic             wrap_down,
   output logic             restart,
   output logic             err,
   output logic             locked,
   output logic [7:0]       err_count
);
   dec_state_t       state;
   logic [WIDTH-1:0] prev;
   logic [3:0]       run;
   step_t            step;
   logic             c_wrap_up;
   logic             c_wrap_down;
   counter_step_classify #(.WIDTH(WIDTH)) u_classify (
      .prev      (prev),
      .cnt_in    (cnt_in),
      .step      (step),
      .wrap_up   (c_wrap_up),
      .wrap_down (c_wrap_down)
   );
   assign locked = state == TRACK;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         prev          <= '0;
         run           <= '0;
         step_valid    <= 1'b0;
         enable_out    <= 1'b0;
         direction_out <= 1'b0;
         wrap_up       <= 1'b0;
         wrap_down     <= 1'b0;
         restart       <= 1'b0;
         err           <= 1'b0;
         err_count     <= '0;
      end else begin
         step_valid <= 1'b0;
         wrap_up    <= 1'b0;
         wrap_down  <= 1'b0;
         restart    <= 1'b0;
         err        <= 1'b0;
         if (cnt_valid) begin
            prev <= cnt_in;
            if (state == IDLE) begin
               state <= TRACK;
            end else begin
               step_valid <= 1'b1;
               wrap_up    <= c_wrap_up;
               wrap_down  <= c_wrap_down;
               restart    <= step == RESTART;
               err        <= step == ILLEGAL;
               // ILLEGAL leaves both recovered controls untouched
               if (step == HOLD || step == RESTART) enable_out <= 1'b0;
               if (step == UP || step == DOWN) begin
                  enable_out    <= 1'b1;
                  direction_out <= step == UP;
               end
               if (step == ILLEGAL) begin
                  state     <= FAULT;
                  run       <= '0;
                  err_count <= err_count == ERR_MAX ? err_count : err_count + 8'd1;
               end else if (state == FAULT) begin
                  state <= run + 4'd1 == 4'(LOCK_LEN) ? TRACK : FAULT;
                  run   <= run + 4'd1 == 4'(LOCK_LEN) ? 4'd0 : run + 4'd1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_counter_decoder.sv
// tb_counter_decoder: scoreboard bench for counter_decoder with directed sample streams
module tb_counter_decoder;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] cnt_in = '0;
   logic       cnt_valid = 1'b0;
   logic       step_valid, enable_out, direction_out, wrap_up, wrap_down, restart, err, locked;
   logic [7:0] err_count;
   logic [14:0] act;
   logic [14:0] q[$];
   int errors = 0;
   int checks = 0;
   counter_decoder #(.WIDTH(8), .LOCK_LEN(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .cnt_in        (cnt_in),
      .cnt_valid     (cnt_valid),
      .step_valid    (step_valid),
      .enable_out    (enable_out),
      .direction_out (direction_out),
      .wrap_up       (wrap_up),
      .wrap_down     (wrap_down),
      .restart       (restart),
      .err           (err),
      .locked        (locked),
      .err_count     (err_count)
   );
   always #5 clk = ~clk;
   assign act = {enable_out, direction_out, wrap_up, wrap_down, restart, err, locked, err_count};
   function automatic logic [14:0] e(input logic en, dir, wu, wd, rs, er, lk, input logic [7:0] ec);
      return {en, dir, wu, wd, rs, er, lk, ec};
   endfunction
   task automatic send(input logic [7:0] v, input bit ex, input logic [14:0] x);
      @(posedge clk);
      #1;
      cnt_in    = v;
      cnt_valid = 1'b1;
      if (ex) q.push_back(x);
   endtask
   task automatic idle();
      @(posedge clk);
      #1;
      cnt_valid = 1'b0;
   endtask
   task automatic check_zero(input string name);
      checks++;
      if ({step_valid, act} !== 16'h0) begin
         errors++;
         $display("FAIL %s: outputs=%h expected=0000", name, {step_valid, act});
      end
   endtask
   task automatic do_reset(input string name);
      idle();
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_zero(name);
      #1;
      rst = 1'b1;
   endtask
   initial begin
      logic [14:0] x;
      fork
         forever begin
            @(negedge clk);
            if (rst && step_valid) begin
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_step: got=%h expected=none", act);
               end else begin
                  x = q.pop_front();
                  if (act !== x) begin
                     errors++;
                     $display("FAIL step: got=%h expected=%h (en,dir,wu,wd,rs,er,lk,cnt)", act, x);
                  end
               end
            end
         end
         begin
            #200000;
            $display("FAIL timeout: bench did not finish");
            $fatal(1, "timeout");
         end
      join_none
      @(negedge clk);
      check_zero("power_on_reset");
      #1 rst = 1'b1;
      // up steps with a no-valid gap after the seed
      send(8'd5, 0, '0);
      idle();
      send(8'd6, 1, e(1, 1, 0, 0, 0, 0, 1, 0));
      send(8'd7, 1, e(1, 1, 0, 0, 0, 0, 1, 0));
      do_reset("reset_g1");
      // down steps, wrap on 0 -> 255 only
      send(8'd1, 0, '0);
      send(8'd0, 1, e(1, 0, 0, 0, 0, 0, 1, 0));
      send(8'd255, 1, e(1, 0, 0, 1, 0, 0, 1, 0));
      send(8'd254, 1, e(1, 0, 0, 0, 0, 0, 1, 0));
      do_reset("reset_g2");
      // up wrap then hold keeps direction
      send(8'd254, 0, '0);
      send(8'd255, 1, e(1, 1, 0, 0, 0, 0, 1, 0));
      send(8'd0, 1, e(1, 1, 1, 0, 0, 0, 1, 0));
      send(8'd0, 1, e(0, 1, 0, 0, 0, 0, 1, 0));
      do_reset("reset_g3");
      // restart is legal
      send(8'd40, 0, '0);
      send(8'd41, 1, e(1, 1, 0, 0, 0, 0, 1, 0));
      send(8'd0, 1, e(0, 1, 0, 0, 1, 0, 1, 0));
      do_reset("reset_g4");
      // illegal step, then relock after two legal steps
      send(8'd10, 0, '0);
      send(8'd11, 1, e(1, 1, 0, 0, 0, 0, 1, 0));
      send(8'd50, 1, e(1, 1, 0, 0, 0, 1, 0, 1));
      send(8'd51, 1, e(1, 1, 0, 0, 0, 0, 0, 1));
      send(8'd52, 1, e(1, 1, 0, 0, 0, 0, 1, 1));
      do_reset("reset_g5");
      // error count saturation
      send(8'd10, 0, '0);
      for (int i = 0; i < 300; i++)
         send(i % 2 ? 8'd10 : 8'd100, 1, e(0, 0, 0, 0, 0, 1, 0, i + 1 > 255 ? 8'd255 : 8'(i + 1)));
      do_reset("midstream_reset");
      // after reset the first sample only seeds again
      send(8'd20, 0, '0);
      send(8'd21, 1, e(1, 1, 0, 0, 0, 0, 1, 0));
      idle();
      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL missing_steps: pending=%0d expected=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
